// File: rtl/cp0_exc_regs_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions and
// the exception-state FSM encoding. ExcCode values live with the exception
// unit and are not repeated here.
package mips_cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam int STATUS_IEC     = 0;
    localparam int STATUS_IM_LSB  = 8;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_IP_LSB   = 8;
    localparam int CAUSE_BD       = 31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        VECTOR = 2'd1,
        HALT   = 2'd2
    } cp0_state_t;

endpackage

// File: rtl/cp0_exc_regs_if.sv
// Pipeline <-> CP0 exception-state interface.
// master: pipeline/exception-unit side (drives exception, RFE, MTC0/MFC0
//         requests and interrupt lines; receives read data, int_req,
//         redirect and halted).
// slave:  CP0 exception register block.
interface cp0_exc_regs_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  exc_valid;
    logic [4:0]            exc_cause;
    logic                  exc_bva_valid;
    logic                  exc_bva_sel;
    logic                  exc_halt;
    logic [31:0]           exc_pc;
    logic                  exc_in_delay_slot;
    logic [31:0]           exc_data_addr;
    logic                  rfe;
    logic                  mtc0_en;
    logic [4:0]            mtc0_reg;
    logic [31:0]           mtc0_data;
    logic [4:0]            mfc0_reg;
    logic [31:0]           mfc0_data;
    logic [NUM_HW_INT-1:0] hw_int;
    logic                  int_req;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  halted;

    modport master (
        output exc_valid, exc_cause, exc_bva_valid, exc_bva_sel, exc_halt,
               exc_pc, exc_in_delay_slot, exc_data_addr, rfe, mtc0_en,
               mtc0_reg, mtc0_data, mfc0_reg, hw_int,
        input  mfc0_data, int_req, redirect_valid, redirect_pc, halted
    );

    modport slave (
        input  exc_valid, exc_cause, exc_bva_valid, exc_bva_sel, exc_halt,
               exc_pc, exc_in_delay_slot, exc_data_addr, rfe, mtc0_en,
               mtc0_reg, mtc0_data, mfc0_reg, hw_int,
        output mfc0_data, int_req, redirect_valid, redirect_pc, halted
    );

endinterface

// File: rtl/cp0_exc_regs_timer.sv
// cp0_timer: Count/Compare pair with a sticky match flag.
// Ports: clk, rst_b (sync, active-low), wr_count/wr_compare strobes with
// shared wdata, count/compare/timer_flag outputs.
// Count free-runs and wraps; a write to Compare clears the flag.
module cp0_timer (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_flag
);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count      <= '0;
            compare    <= '0;
            timer_flag <= 1'b0;
        end else begin
            count <= wr_count ? wdata : count + 32'd1;
            if (wr_compare) begin
                compare    <= wdata;
                timer_flag <= 1'b0;
            end else if (count == compare) begin
                timer_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_regs.sv
// cp0_exc_regs: CP0 exception state (EPC, Cause, BadVAddr, Status KU/IE
// stack), exception-vector redirect, RFE/MTC0/MFC0 servicing and the
// interrupt request back to the pipeline.
// Ports: clk, rst_b (sync, active-low), bus (cp0_exc_regs_if.slave).
// Optional: define CP0_COUNT_COMPARE_EN to add Count (9) / Compare (11)
// with a timer interrupt on IP[7].
//
// state  | meaning
// RUN    | normal execution; accepts exceptions, RFE and MTC0
// VECTOR | one-cycle redirect to EXC_VECTOR while the pipeline flushes
// HALT   | fatal instruction-side error; sticky until reset
module cp0_exc_regs
    import mips_cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0080,
    parameter int          NUM_HW_INT = 6,
    parameter logic [31:0] PRID_VALUE = 32'h0000_0200
) (
    input  logic           clk,
    input  logic           rst_b,
    cp0_exc_regs_if.slave  bus
);

    cp0_state_t  state, state_nxt;
    logic        take_exc, take_rfe, take_mtc0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    logic [7:0]  status_im;
    logic [5:0]  status_ku_ie;
    logic        cause_bd;
    logic [1:0]  cause_ip_sw;
    logic [5:0]  ip_hw;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] bad_vaddr;

    logic [5:0]  hw_int_ext;
    logic        ip7;
    logic [7:0]  cause_ip;
    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic [31:0] mfc0_data;

    always_comb begin
        hw_int_ext                 = '0;
        hw_int_ext[NUM_HW_INT-1:0] = bus.hw_int;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;
        take_exc       = 1'b0;
        take_rfe       = 1'b0;
        take_mtc0      = 1'b0;
        case (state)
            RUN: begin
                if (bus.exc_halt) begin
                    state_nxt = HALT;
                end else if (bus.exc_valid) begin
                    take_exc  = 1'b1;
                    state_nxt = VECTOR;
                end else if (bus.rfe) begin
                    take_rfe = 1'b1;
                end else if (bus.mtc0_en) begin
                    take_mtc0 = 1'b1;
                end
            end
            VECTOR: begin
                redirect_valid = 1'b1;
                redirect_pc    = EXC_VECTOR;
                state_nxt      = RUN;
            end
            HALT: halted = 1'b1;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            status_im    <= '0;
            status_ku_ie <= '0;
            cause_bd     <= 1'b0;
            cause_ip_sw  <= '0;
            ip_hw        <= '0;
            cause_exc    <= '0;
            epc          <= '0;
            bad_vaddr    <= '0;
        end else begin
            ip_hw <= hw_int_ext;
            if (take_exc) begin
                // Delay-slot faults restart at the branch, one word earlier.
                epc          <= bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                cause_bd     <= bus.exc_in_delay_slot;
                cause_exc    <= bus.exc_cause;
                status_ku_ie <= {status_ku_ie[3:0], 2'b00};
                if (bus.exc_bva_valid)
                    bad_vaddr <= bus.exc_bva_sel ? bus.exc_data_addr : bus.exc_pc;
            end else if (take_rfe) begin
                status_ku_ie <= {status_ku_ie[5:4], status_ku_ie[5:2]};
            end else if (take_mtc0) begin
                case (bus.mtc0_reg)
                    CP0_STATUS: begin
                        status_im    <= bus.mtc0_data[15:8];
                        status_ku_ie <= bus.mtc0_data[5:0];
                    end
                    CP0_CAUSE: cause_ip_sw <= bus.mtc0_data[9:8];
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_COUNT_COMPARE_EN
    logic [31:0] count, compare;
    logic        timer_flag;

    cp0_timer u_timer (
        .clk        (clk),
        .rst_b      (rst_b),
        .wr_count   (take_mtc0 && bus.mtc0_reg == CP0_COUNT),
        .wr_compare (take_mtc0 && bus.mtc0_reg == CP0_COMPARE),
        .wdata      (bus.mtc0_data),
        .count      (count),
        .compare    (compare),
        .timer_flag (timer_flag)
    );

    assign ip7 = ip_hw[5] | timer_flag;
`else
    assign ip7 = ip_hw[5];
`endif

    // Bits of the write bus that no implemented register field consumes.
    logic unused_wdata;
    assign unused_wdata = ^bus.mtc0_data;

    assign cause_ip    = {ip7, ip_hw[4:0], cause_ip_sw};
    assign status_word = {16'b0, status_im, 2'b00, status_ku_ie};
    assign cause_word  = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exc, 2'b00};

    always_comb begin
        mfc0_data = '0;
        case (bus.mfc0_reg)
            CP0_BADVADDR: mfc0_data = bad_vaddr;
            CP0_STATUS:   mfc0_data = status_word;
            CP0_CAUSE:    mfc0_data = cause_word;
            CP0_EPC:      mfc0_data = epc;
            CP0_PRID:     mfc0_data = PRID_VALUE;
`ifdef CP0_COUNT_COMPARE_EN
            CP0_COUNT:    mfc0_data = count;
            CP0_COMPARE:  mfc0_data = compare;
`endif
            default:      mfc0_data = '0;
        endcase
    end

    assign bus.mfc0_data      = mfc0_data;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.halted         = halted;
    assign bus.int_req        = (state == RUN) & status_ku_ie[STATUS_IEC]
                                & (|(cause_ip & status_im));

endmodule

// File: tb/tb_cp0_exc_regs.sv
// Directed self-checking bench for cp0_exc_regs (default build).
module tb_cp0_exc_regs;
    import mips_cp0_pkg::*;

    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_OV   = 5'd12;

    logic clk = 1'b0;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    always #10 clk = ~clk;

    cp0_exc_regs_if #(.NUM_HW_INT(6)) bus ();

    cp0_exc_regs dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] r, input logic [31:0] exp);
        bus.mfc0_reg = r;
        #1;
        chk(tag, bus.mfc0_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        bus.mtc0_en   = 1'b1;
        bus.mtc0_reg  = r;
        bus.mtc0_data = d;
        tick();
        bus.mtc0_en = 1'b0;
    endtask

    task automatic clear_exc();
        bus.exc_valid         = 1'b0;
        bus.exc_halt          = 1'b0;
        bus.exc_bva_valid     = 1'b0;
        bus.exc_bva_sel       = 1'b0;
        bus.exc_in_delay_slot = 1'b0;
        bus.rfe               = 1'b0;
        bus.mtc0_en           = 1'b0;
    endtask

    initial begin
        rst_b             = 1'b0;
        bus.exc_cause     = '0;
        bus.exc_pc        = '0;
        bus.exc_data_addr = '0;
        bus.mtc0_reg      = '0;
        bus.mtc0_data     = '0;
        bus.mfc0_reg      = '0;
        bus.hw_int        = '0;
        clear_exc();
        tick();
        tick();
        rst_b = 1'b1;

        // Reset state
        chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_int_req", {31'b0, bus.int_req}, 32'd0);
        chk("rst_halted", {31'b0, bus.halted}, 32'd0);
        rd("rst_status", CP0_STATUS, 32'd0);
        rd("rst_cause", CP0_CAUSE, 32'd0);
        tick();
        rd("rst_epc", CP0_EPC, 32'd0);
        rd("rst_bva", CP0_BADVADDR, 32'd0);
        rd("prid", CP0_PRID, 32'h0000_0200);
        rd("count_disabled", CP0_COUNT, 32'd0);
        rd("unmapped_reg", 5'd31, 32'd0);

        // Overflow exception, then reset while redirect is active
        mtc0(CP0_STATUS, 32'h0000_0001);
        rd("status_ie", CP0_STATUS, 32'h0000_0001);
        bus.exc_valid = 1'b1;
        bus.exc_cause = EX_OV;
        bus.exc_pc    = 32'h0040_0010;
        tick();
        clear_exc();
        chk("ov_redirect_valid", {31'b0, bus.redirect_valid}, 32'd1);
        chk("ov_redirect_pc", bus.redirect_pc, 32'h8000_0080);
        rd("ov_epc", CP0_EPC, 32'h0040_0010);
        rd("ov_cause", CP0_CAUSE, 32'h0000_0030);
        rd("ov_status", CP0_STATUS, 32'h0000_0004);
        rd("ov_bva", CP0_BADVADDR, 32'd0);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("midvec_rst_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        rd("midvec_rst_status", CP0_STATUS, 32'd0);
        rd("midvec_rst_cause", CP0_CAUSE, 32'd0);
        rd("midvec_rst_epc", CP0_EPC, 32'd0);
        tick();
        chk("midvec_rst_run", {31'b0, bus.redirect_valid}, 32'd0);

        // Redirect lasts exactly one cycle
        bus.exc_valid = 1'b1;
        bus.exc_cause = EX_OV;
        bus.exc_pc    = 32'h0040_0010;
        tick();
        clear_exc();
        chk("vec_one_cycle_a", {31'b0, bus.redirect_valid}, 32'd1);
        tick();
        chk("vec_one_cycle_b", {31'b0, bus.redirect_valid}, 32'd0);
        chk("vec_pc_zero", bus.redirect_pc, 32'd0);

        // AdES in a delay slot, BadVAddr from data address
        bus.exc_valid         = 1'b1;
        bus.exc_cause         = EX_ADES;
        bus.exc_in_delay_slot = 1'b1;
        bus.exc_pc            = 32'h0040_0024;
        bus.exc_data_addr     = 32'h1000_0003;
        bus.exc_bva_valid     = 1'b1;
        bus.exc_bva_sel       = 1'b1;
        tick();
        clear_exc();
        rd("ades_epc", CP0_EPC, 32'h0040_0020);
        rd("ades_cause", CP0_CAUSE, 32'h8000_0014);
        rd("ades_bva", CP0_BADVADDR, 32'h1000_0003);
        tick();

        // Delay-slot EPC wraps below zero; BadVAddr from PC
        bus.exc_valid         = 1'b1;
        bus.exc_cause         = EX_ADEL;
        bus.exc_in_delay_slot = 1'b1;
        bus.exc_pc            = 32'h0000_0002;
        bus.exc_bva_valid     = 1'b1;
        bus.exc_bva_sel       = 1'b0;
        tick();
        clear_exc();
        rd("wrap_epc", CP0_EPC, 32'hFFFF_FFFE);
        rd("wrap_bva", CP0_BADVADDR, 32'h0000_0002);
        rd("wrap_cause", CP0_CAUSE, 32'h8000_0010);
        tick();

        // Exception beats RFE and MTC0 in the same cycle; VECTOR ignores both
        mtc0(CP0_STATUS, 32'h0000_0001);
        bus.exc_valid = 1'b1;
        bus.exc_cause = EX_SYS;
        bus.exc_pc    = 32'h0040_0200;
        bus.rfe       = 1'b1;
        bus.mtc0_en   = 1'b1;
        bus.mtc0_reg  = CP0_STATUS;
        bus.mtc0_data = 32'h0000_FFFF;
        tick();
        bus.exc_valid = 1'b0;
        chk("prio_redirect", {31'b0, bus.redirect_valid}, 32'd1);
        rd("prio_status", CP0_STATUS, 32'h0000_0004);
        rd("prio_epc", CP0_EPC, 32'h0040_0200);
        rd("prio_cause", CP0_CAUSE, 32'h0000_0020);
        rd("prio_bva", CP0_BADVADDR, 32'h0000_0002);
        tick();
        clear_exc();
        rd("vector_ignores", CP0_STATUS, 32'h0000_0004);
        bus.rfe = 1'b1;
        tick();
        bus.rfe = 1'b0;
        rd("rfe_status", CP0_STATUS, 32'h0000_0001);

        // MTC0 field masks
        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        rd("status_mask", CP0_STATUS, 32'h0000_FF3F);
        chk("no_ip_int", {31'b0, bus.int_req}, 32'd0);
        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        rd("cause_mask", CP0_CAUSE, 32'h0000_0320);
        chk("sw_ip_int", {31'b0, bus.int_req}, 32'd1);
        mtc0(CP0_CAUSE, 32'd0);
        rd("cause_clear", CP0_CAUSE, 32'h0000_0020);
        chk("sw_ip_int_off", {31'b0, bus.int_req}, 32'd0);
        mtc0(CP0_EPC, 32'h0000_1234);
        rd("epc_ro", CP0_EPC, 32'h0040_0200);
        mtc0(CP0_BADVADDR, 32'h0000_1234);
        rd("bva_ro", CP0_BADVADDR, 32'h0000_0002);
        mtc0(CP0_COUNT, 32'd5);
        rd("count_wr_ignored", CP0_COUNT, 32'd0);

        // Hardware interrupt path
        mtc0(CP0_STATUS, 32'h0000_0401);
        chk("hw_int_idle", {31'b0, bus.int_req}, 32'd0);
        bus.hw_int = 6'h01;
        tick();
        chk("hw_int0_req", {31'b0, bus.int_req}, 32'd1);
        rd("hw_int0_cause", CP0_CAUSE, 32'h0000_0420);
        mtc0(CP0_STATUS, 32'h0000_0400);
        chk("iec_clear", {31'b0, bus.int_req}, 32'd0);
        bus.hw_int = 6'h20;
        mtc0(CP0_STATUS, 32'h0000_8001);
        rd("hw_int5_cause", CP0_CAUSE, 32'h0000_8020);
        chk("hw_int5_req", {31'b0, bus.int_req}, 32'd1);
        bus.hw_int = 6'h00;
        tick();
        chk("hw_int_drop", {31'b0, bus.int_req}, 32'd0);

        // Halt wins over exception and is sticky until reset
        mtc0(CP0_STATUS, 32'h0000_0401);
        bus.hw_int = 6'h01;
        tick();
        chk("pre_halt_int", {31'b0, bus.int_req}, 32'd1);
        bus.exc_halt      = 1'b1;
        bus.exc_valid     = 1'b1;
        bus.exc_cause     = EX_OV;
        bus.exc_pc        = 32'h1234_5678;
        bus.exc_bva_valid = 1'b1;
        tick();
        clear_exc();
        chk("halt_halted", {31'b0, bus.halted}, 32'd1);
        chk("halt_no_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        chk("halt_int_masked", {31'b0, bus.int_req}, 32'd0);
        rd("halt_epc", CP0_EPC, 32'h0040_0200);
        rd("halt_bva", CP0_BADVADDR, 32'h0000_0002);
        rd("halt_status", CP0_STATUS, 32'h0000_0401);
        bus.exc_valid = 1'b1;
        bus.rfe       = 1'b1;
        bus.mtc0_en   = 1'b1;
        bus.mtc0_reg  = CP0_STATUS;
        bus.mtc0_data = 32'd0;
        tick();
        tick();
        clear_exc();
        chk("halt_sticky", {31'b0, bus.halted}, 32'd1);
        chk("halt_sticky_redirect", {31'b0, bus.redirect_valid}, 32'd0);
        rd("halt_sticky_status", CP0_STATUS, 32'h0000_0401);
        rd("halt_sticky_epc", CP0_EPC, 32'h0040_0200);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        bus.hw_int = 6'h00;
        chk("halt_rst", {31'b0, bus.halted}, 32'd0);
        rd("halt_rst_status", CP0_STATUS, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
